// File: rtl/clint_timer_sched.sv
// clint_timer_sched
// Shares the single CLINT mtime/mtimecmp comparison between NrTimers software
// timer channels. Requests arm or cancel per-channel deadlines. A sequential
// scan then finds the earliest armed deadline and drives it on mtimecmp_o.
// When mtime reaches that deadline, the owning channel's interrupt latches
// and a rescan starts.
module clint_timer_sched #(
  parameter  int unsigned NrTimers = 4,
  localparam int unsigned IdxWidth = (NrTimers > 1) ? $clog2(NrTimers) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [63:0]         mtime_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_op_i,
  input  logic [IdxWidth-1:0] req_id_i,
  input  logic [63:0]         req_deadline_i,
  input  logic [NrTimers-1:0] ack_i,
  output logic [NrTimers-1:0] irq_o,
  output logic [NrTimers-1:0] armed_o,
  output logic [63:0]         mtimecmp_o,
  output logic                mtimecmp_valid_o
);

  localparam logic [0:0]          StIdle  = 1'b0;
  localparam logic [0:0]          StScan  = 1'b1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NrTimers - 1);
  localparam logic [63:0]         AllOnes = {64{1'b1}};

  // Per-channel state
  logic [63:0]         deadline_q [NrTimers];
  logic [63:0]         deadline_d [NrTimers];
  logic [NrTimers-1:0] armed_q, armed_d;
  logic [NrTimers-1:0] pending_q, pending_d;
  logic [NrTimers-1:0] fire_set_s;

  // Global state
  logic [0:0]          state_q, state_d;
  logic [IdxWidth-1:0] scan_cnt_q, scan_cnt_d;
  logic                found_q, found_d;
  logic [63:0]         run_min_q, run_min_d;
  logic [IdxWidth-1:0] run_idx_q, run_idx_d;
  logic [IdxWidth-1:0] min_idx_q, min_idx_d;
  logic [63:0]         mtimecmp_q, mtimecmp_d;
  logic                cmp_valid_q, cmp_valid_d;

  // Combinational helpers
  logic                fire_s;
  logic                req_accept_s;
  logic                id_ok_s;
  logic                scan_take_s;
  logic [63:0]         scan_min_s;
  logic [IdxWidth-1:0] scan_idx_s;
  logic                scan_found_s;

  // Firing only happens in IDLE, so the scan never sees armed_q change under it.
  assign fire_s       = (state_q == StIdle) & cmp_valid_q & (mtime_i >= mtimecmp_q);
  assign req_ready_o  = (state_q == StIdle) & ~fire_s;
  assign req_accept_s = req_valid_i & req_ready_o;
  // Ids beyond NrTimers (non power-of-two counts) are accepted but ignored.
  assign id_ok_s      = (32'(req_id_i) < NrTimers);

  // The strict less-than keeps the lowest index on equal deadlines.
  assign scan_take_s  = armed_q[scan_cnt_q] &
                        (~found_q | (deadline_q[scan_cnt_q] < run_min_q));
  assign scan_min_s   = scan_take_s ? deadline_q[scan_cnt_q] : run_min_q;
  assign scan_idx_s   = scan_take_s ? scan_cnt_q : run_idx_q;
  assign scan_found_s = found_q | scan_take_s;

  assign irq_o            = pending_q;
  assign armed_o          = armed_q;
  assign mtimecmp_o       = mtimecmp_q;
  assign mtimecmp_valid_o = cmp_valid_q & (state_q == StIdle);

  // Next-state logic: fire/request handling in IDLE, running minimum in SCAN.
  always_comb begin
    state_d     = state_q;
    scan_cnt_d  = scan_cnt_q;
    found_d     = found_q;
    run_min_d   = run_min_q;
    run_idx_d   = run_idx_q;
    min_idx_d   = min_idx_q;
    mtimecmp_d  = mtimecmp_q;
    cmp_valid_d = cmp_valid_q;
    deadline_d  = deadline_q;
    armed_d     = armed_q;
    fire_set_s  = '0;

    case (state_q)
      StIdle: begin
        if (fire_s) begin
          armed_d[min_idx_q]    = 1'b0;
          fire_set_s[min_idx_q] = 1'b1;
          state_d               = StScan;
        end else if (req_accept_s) begin
          if (id_ok_s) begin
            if (req_op_i == 1'b0) begin
              deadline_d[req_id_i] = req_deadline_i;
              armed_d[req_id_i]    = 1'b1;
            end else begin
              armed_d[req_id_i]    = 1'b0;
            end
          end else begin
            armed_d = armed_q;
          end
          state_d = StScan;
        end else begin
          state_d = StIdle;
        end
        // Every scan starts from an empty running minimum.
        scan_cnt_d = '0;
        found_d    = 1'b0;
        run_min_d  = AllOnes;
        run_idx_d  = '0;
      end
      StScan: begin
        if (scan_cnt_q == LastIdx) begin
          mtimecmp_d  = scan_found_s ? scan_min_s : AllOnes;
          cmp_valid_d = scan_found_s;
          min_idx_d   = scan_idx_s;
          state_d     = StIdle;
        end else begin
          scan_cnt_d  = scan_cnt_q + IdxWidth'(1);
          found_d     = scan_found_s;
          run_min_d   = scan_min_s;
          run_idx_d   = scan_idx_s;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Acks clear in any state. A simultaneous fire on the same channel wins.
    pending_d = (pending_q & ~ack_i) | fire_set_s;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      scan_cnt_q  <= '0;
      found_q     <= 1'b0;
      run_min_q   <= AllOnes;
      run_idx_q   <= '0;
      min_idx_q   <= '0;
      mtimecmp_q  <= AllOnes;
      cmp_valid_q <= 1'b0;
      deadline_q  <= '{default: 64'd0};
      armed_q     <= '0;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      scan_cnt_q  <= scan_cnt_d;
      found_q     <= found_d;
      run_min_q   <= run_min_d;
      run_idx_q   <= run_idx_d;
      min_idx_q   <= min_idx_d;
      mtimecmp_q  <= mtimecmp_d;
      cmp_valid_q <= cmp_valid_d;
      deadline_q  <= deadline_d;
      armed_q     <= armed_d;
      pending_q   <= pending_d;
    end
  end

endmodule

// File: tb/tb_clint_timer_sched.sv
// tb_clint_timer_sched
// Directed stimulus. Each step pushes the expected output vector and the cycle
// at which it must appear. A negedge monitor pops and compares on every change
// of {irq_o, armed_o, mtimecmp_valid_o, mtimecmp_o}.
module tb_clint_timer_sched;

  localparam logic [63:0] ONES = {64{1'b1}};

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [63:0] mtime_i = 64'd0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_op_i = 1'b0;
  logic [1:0]  req_id_i = 2'd0;
  logic [63:0] req_deadline_i = 64'd0;
  logic [3:0]  ack_i = 4'd0;
  logic [3:0]  irq_o;
  logic [3:0]  armed_o;
  logic [63:0] mtimecmp_o;
  logic        mtimecmp_valid_o;

  clint_timer_sched #(.NrTimers(4)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .mtime_i          (mtime_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_op_i         (req_op_i),
    .req_id_i         (req_id_i),
    .req_deadline_i   (req_deadline_i),
    .ack_i            (ack_i),
    .irq_o            (irq_o),
    .armed_o          (armed_o),
    .mtimecmp_o       (mtimecmp_o),
    .mtimecmp_valid_o (mtimecmp_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [72:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  logic [72:0] mon_cur;
  logic [72:0] mon_prev = '0;
  exp_t        mon_e;

  // Monitor: every output change must match the next expected vector and cycle.
  always @(negedge clk_i) begin
    mon_cur = {irq_o, armed_o, mtimecmp_valid_o, mtimecmp_o};
    if (mon_en && (mon_cur !== mon_prev)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL out_change_unexpected cyc=%0d got=%h", cyc, mon_cur);
      end else begin
        mon_e = exp_q.pop_front();
        if ((mon_e.vec !== mon_cur) || (mon_e.cyc != cyc)) begin
          n_err++;
          $display("FAIL out_vec got cyc=%0d vec=%h, want cyc=%0d vec=%h",
                   cyc, mon_cur, mon_e.cyc, mon_e.vec);
        end
      end
    end
    mon_prev = mon_cur;
  end

  task automatic push(input int c, input logic [3:0] irq, input logic [3:0] arm,
                      input logic v, input logic [63:0] cmp);
    exp_t s;
    s.cyc = c;
    s.vec = {irq, arm, v, cmp};
    exp_q.push_back(s);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Issues one request, returns the index of the clock edge that accepted it.
  task automatic do_req(input logic op, input logic [1:0] id, input logic [63:0] dl,
                        output int acc);
    int waited;
    waited         = 0;
    acc            = -1;
    req_valid_i    = 1'b1;
    req_op_i       = op;
    req_id_i       = id;
    req_deadline_i = dl;
    while (acc < 0) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        acc = cyc + 1;
      end else begin
        waited++;
        if (waited > 100) begin
          n_cmp++;
          n_err++;
          $display("FAIL req_timeout cyc=%0d got=no_accept want=accept", cyc);
          acc = cyc + 1;
        end
      end
    end
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  initial begin
    int a, b, f, g;

    // Reset state
    @(negedge clk_i);
    chk("rst_irq", 64'(irq_o), 64'd0);
    chk("rst_armed", 64'(armed_o), 64'd0);
    chk("rst_cmp", mtimecmp_o, ONES);
    chk("rst_valid", 64'(mtimecmp_valid_o), 64'd0);
    chk("rst_ready", 64'(req_ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    mon_en = 1'b1;

    // Single timer: arm, scan latency, fire, ack
    tick(1);
    mtime_i = 64'd10;
    do_req(1'b0, 2'd2, 64'd100, a);
    push(a,     4'b0000, 4'b0100, 1'b0, ONES);
    push(a + 4, 4'b0000, 4'b0100, 1'b1, 64'd100);
    repeat (4) begin
      @(negedge clk_i);
      chk("ready_low_scan", 64'(req_ready_o), 64'd0);
    end
    @(negedge clk_i);
    chk("ready_after_scan", 64'(req_ready_o), 64'd1);
    tick(2);
    f = cyc;
    mtime_i = 64'd100;
    push(f + 1, 4'b0100, 4'b0000, 1'b0, 64'd100);
    push(f + 5, 4'b0100, 4'b0000, 1'b0, ONES);
    @(negedge clk_i);
    chk("ready_low_fire", 64'(req_ready_o), 64'd0);
    tick(6);
    g = cyc;
    ack_i = 4'b0100;
    push(g + 1, 4'b0000, 4'b0000, 1'b0, ONES);
    tick(1);
    ack_i = 4'b0000;

    // Equal deadlines fire in ascending index order, 5 cycles apart
    tick(1);
    mtime_i = 64'd0;
    do_req(1'b0, 2'd3, 64'd50, a);
    push(a,     4'b0000, 4'b1000, 1'b0, ONES);
    push(a + 4, 4'b0000, 4'b1000, 1'b1, 64'd50);
    do_req(1'b0, 2'd1, 64'd50, a);
    push(a,     4'b0000, 4'b1010, 1'b0, 64'd50);
    push(a + 4, 4'b0000, 4'b1010, 1'b1, 64'd50);
    do_req(1'b0, 2'd0, 64'd80, a);
    push(a,     4'b0000, 4'b1011, 1'b0, 64'd50);
    push(a + 4, 4'b0000, 4'b1011, 1'b1, 64'd50);
    tick(5);
    f = cyc;
    mtime_i = 64'd50;
    push(f + 1,  4'b0010, 4'b1001, 1'b0, 64'd50);
    push(f + 5,  4'b0010, 4'b1001, 1'b1, 64'd50);
    push(f + 6,  4'b1010, 4'b0001, 1'b0, 64'd50);
    push(f + 10, 4'b1010, 4'b0001, 1'b1, 64'd80);
    tick(12);
    g = cyc;
    ack_i = 4'b1010;
    push(g + 1, 4'b0000, 4'b0001, 1'b1, 64'd80);
    tick(1);
    ack_i = 4'b0000;
    do_req(1'b1, 2'd0, 64'd0, a);
    push(a,     4'b0000, 4'b0000, 1'b0, 64'd80);
    push(a + 4, 4'b0000, 4'b0000, 1'b0, ONES);

    // Cancel the current minimum, then the last armed channel
    do_req(1'b0, 2'd0, 64'd200, a);
    push(a,     4'b0000, 4'b0001, 1'b0, ONES);
    push(a + 4, 4'b0000, 4'b0001, 1'b1, 64'd200);
    do_req(1'b0, 2'd1, 64'd300, a);
    push(a,     4'b0000, 4'b0011, 1'b0, 64'd200);
    push(a + 4, 4'b0000, 4'b0011, 1'b1, 64'd200);
    do_req(1'b1, 2'd0, 64'd0, a);
    push(a,     4'b0000, 4'b0010, 1'b0, 64'd200);
    push(a + 4, 4'b0000, 4'b0010, 1'b1, 64'd300);
    do_req(1'b1, 2'd1, 64'd0, a);
    push(a,     4'b0000, 4'b0000, 1'b0, 64'd300);
    push(a + 4, 4'b0000, 4'b0000, 1'b0, ONES);
    tick(5);

    // Deadline already past: fires right after the scan; held request waits
    mtime_i = 64'd1000;
    do_req(1'b0, 2'd1, 64'd5, a);
    push(a,     4'b0000, 4'b0010, 1'b0, ONES);
    push(a + 4, 4'b0000, 4'b0010, 1'b1, 64'd5);
    push(a + 5, 4'b0010, 4'b0000, 1'b0, 64'd5);
    push(a + 9, 4'b0010, 4'b0000, 1'b0, ONES);
    do_req(1'b0, 2'd2, 64'd2000, b);
    chk("accept_after_fire_cycle", 64'(b), 64'(a + 10));
    push(b,     4'b0010, 4'b0100, 1'b0, ONES);
    push(b + 4, 4'b0010, 4'b0100, 1'b1, 64'd2000);
    tick(5);
    g = cyc;
    ack_i = 4'b0010;
    push(g + 1, 4'b0000, 4'b0100, 1'b1, 64'd2000);
    tick(1);
    ack_i = 4'b0000;

    // Ack in the fire cycle loses; ack during SCAN is honoured
    tick(1);
    f = cyc;
    mtime_i = 64'd2000;
    ack_i = 4'b0100;
    push(f + 1, 4'b0100, 4'b0000, 1'b0, 64'd2000);
    push(f + 3, 4'b0000, 4'b0000, 1'b0, 64'd2000);
    push(f + 5, 4'b0000, 4'b0000, 1'b0, ONES);
    tick(1);
    ack_i = 4'b0000;
    tick(1);
    ack_i = 4'b0100;
    tick(1);
    ack_i = 4'b0000;
    tick(4);

    // Reset asserted mid-SCAN
    do_req(1'b0, 2'd0, 64'd5000, a);
    push(a, 4'b0000, 4'b0001, 1'b0, ONES);
    tick(1);
    push(a + 1, 4'b0000, 4'b0000, 1'b0, ONES);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("midscan_rst_ready", 64'(req_ready_o), 64'd1);
    chk("midscan_rst_armed", 64'(armed_o), 64'd0);
    chk("midscan_rst_cmp", mtimecmp_o, ONES);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    tick(8);
    chk("post_rst_ready", 64'(req_ready_o), 64'd1);
    chk("post_rst_valid", 64'(mtimecmp_valid_o), 64'd0);

    chk("exp_queue_left", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
